// File: rtl/frame_seq_pkg.sv
// Shared types and constants for the per-frame sprite scheduler.
package frame_seq_pkg;

    localparam int X_W = 9;
    localparam int Y_W = 8;
    localparam int C_W = 3;

    // Cycles each sprite engine spends loading/waiting before its first real pixel.
    localparam int ENGINE_PREAMBLE = 3;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ERASE      = 2'd1,
        DRAW       = 2'd2,
        DONE       = 2'd3
    } seq_state_e;

endpackage

// File: rtl/frame_sequencer_tick_gen.sv
// Free-running frame timer: emits a one-cycle tick every FRAME_TICKS clocks.
module frame_tick_gen
    import frame_seq_pkg::*;
#(
    parameter int FRAME_TICKS = 833333
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_TICKS - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        tick    = (count_q == LAST);
        count_d = tick ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler: erases then redraws each sprite engine in index order
// and muxes the active engine's pixel stream onto the single VGA port.
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int NUM_SPRITES  = 3,
    parameter int FRAME_TICKS  = 833333,
    parameter int ERASE_HOLD   = 45,
    parameter int DRAW_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SPRITES-1:0]     sprite_finish,
    input  logic [X_W*NUM_SPRITES-1:0] sprite_x,
    input  logic [Y_W*NUM_SPRITES-1:0] sprite_y,
    input  logic [C_W*NUM_SPRITES-1:0] sprite_colour,
    output logic [NUM_SPRITES-1:0]     draw_signal,
    output logic [NUM_SPRITES-1:0]     erase_signal,
    output logic [X_W-1:0]             vga_x,
    output logic [Y_W-1:0]             vga_y,
    output logic [C_W-1:0]             vga_colour,
    output logic                       vga_plot,
    output logic [15:0]                frame_count,
    output logic                       overrun,
    output logic                       timeout_err
);

    localparam int IDX_W   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int CYC_MAX = (ERASE_HOLD > DRAW_TIMEOUT) ? ERASE_HOLD : DRAW_TIMEOUT;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
    localparam logic [CYC_W-1:0] HOLD_C   = CYC_W'(ERASE_HOLD);
    localparam logic [CYC_W-1:0] TMO_C    = CYC_W'(DRAW_TIMEOUT - 1);
    localparam logic [CYC_W-1:0] PRE_C    = CYC_W'(ENGINE_PREAMBLE);

    logic tick;

    frame_tick_gen #(.FRAME_TICKS(FRAME_TICKS)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    seq_state_e              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CYC_W-1:0]        cyc_q, cyc_d;
    logic                    gap_q, gap_d;
    logic                    pending_q, pending_d;
    logic                    first_q, first_d;
    logic [15:0]             frame_count_q, frame_count_d;
    logic                    overrun_q, overrun_d;
    logic                    timeout_q, timeout_d;
    logic [NUM_SPRITES-1:0]  draw_q, draw_d;
    logic [NUM_SPRITES-1:0]  erase_q, erase_d;
    logic                    plot_q, plot_d;
    logic                    consume;
    logic                    req_active;

    logic [X_W-1:0] x_arr [NUM_SPRITES];
    logic [Y_W-1:0] y_arr [NUM_SPRITES];
    logic [C_W-1:0] c_arr [NUM_SPRITES];

    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_unpack
        assign x_arr[gi] = sprite_x[gi*X_W +: X_W];
        assign y_arr[gi] = sprite_y[gi*Y_W +: Y_W];
        assign c_arr[gi] = sprite_colour[gi*C_W +: C_W];
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cyc_d         = cyc_q;
        gap_d         = gap_q;
        pending_d     = pending_q;
        first_d       = first_q;
        frame_count_d = frame_count_q;
        overrun_d     = overrun_q;
        timeout_d     = timeout_q;
        consume       = 1'b0;

        case (state_q)
            WAIT_FRAME: begin
                if (pending_q) begin
                    consume = 1'b1;
                    idx_d   = '0;
                    cyc_d   = '0;
                    gap_d   = 1'b0;
                    state_d = first_q ? DRAW : ERASE;
                end
            end
            ERASE: begin
                // cyc == HOLD is the all-zero gap cycle before the next request
                if (cyc_q == HOLD_C) begin
                    cyc_d = '0;
                    gap_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = DRAW;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            DRAW: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                    cyc_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (sprite_finish[idx_q]) begin
                    gap_d = 1'b1;
                end else if (cyc_q == TMO_C) begin
                    gap_d     = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            DONE: begin
                frame_count_d = frame_count_q + 16'd1;
                first_d       = 1'b0;
                state_d       = WAIT_FRAME;
            end
            default: state_d = WAIT_FRAME;
        endcase

        // A tick landing on the consume cycle refills the flag rather than overrunning.
        if (consume) begin
            pending_d = 1'b0;
        end
        if (tick) begin
            if (pending_q && !consume) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        // Request outputs are decoded from the next state so they come straight off flops.
        erase_d    = '0;
        draw_d     = '0;
        req_active = 1'b0;
        if (state_d == ERASE && cyc_d < HOLD_C) begin
            erase_d[idx_d] = 1'b1;
            req_active     = 1'b1;
        end
        if (state_d == DRAW && !gap_d) begin
            draw_d[idx_d] = 1'b1;
            req_active    = 1'b1;
        end
        plot_d = req_active && (cyc_d >= PRE_C);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= WAIT_FRAME;
            idx_q         <= '0;
            cyc_q         <= '0;
            gap_q         <= 1'b0;
            pending_q     <= 1'b0;
            first_q       <= 1'b1;
            frame_count_q <= '0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
            draw_q        <= '0;
            erase_q       <= '0;
            plot_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cyc_q         <= cyc_d;
            gap_q         <= gap_d;
            pending_q     <= pending_d;
            first_q       <= first_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
            draw_q        <= draw_d;
            erase_q       <= erase_d;
            plot_q        <= plot_d;
        end
    end

    // Pixel bus is parked at zero whenever no engine holds a request.
    logic bus_active;
    assign bus_active   = (|draw_q) || (|erase_q);
    assign vga_x        = bus_active ? x_arr[idx_q] : '0;
    assign vga_y        = bus_active ? y_arr[idx_q] : '0;
    assign vga_colour   = bus_active ? c_arr[idx_q] : '0;
    assign vga_plot     = plot_q;
    assign draw_signal  = draw_q;
    assign erase_signal = erase_q;
    assign frame_count  = frame_count_q;
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized bench: a frame-level schedule model predicts every request pulse,
// plot window, pixel value and status flag; a second instance stresses overrun.
module tb_frame_sequencer;

    localparam int N     = 3;
    localparam int FT    = 200;
    localparam int FT_B  = 50;
    localparam int EH    = 45;
    localparam int DT    = 64;
    localparam int PRE   = 3;
    localparam int NEVER = 32'h3fff_ffff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [N-1:0]   fin_a, fin_b;
    logic [9*N-1:0] sx;
    logic [8*N-1:0] sy;
    logic [3*N-1:0] sc;

    logic [N-1:0] draw_a, erase_a, draw_b, erase_b;
    logic [8:0]   vx_a, vx_b;
    logic [7:0]   vy_a, vy_b;
    logic [2:0]   vc_a, vc_b;
    logic         plot_a, plot_b, ov_a, ov_b, to_a, to_b;
    logic [15:0]  fc_a, fc_b;

    frame_sequencer #(.NUM_SPRITES(N), .FRAME_TICKS(FT), .ERASE_HOLD(EH), .DRAW_TIMEOUT(DT)) dut (
        .clk(clk), .reset(reset), .sprite_finish(fin_a),
        .sprite_x(sx), .sprite_y(sy), .sprite_colour(sc),
        .draw_signal(draw_a), .erase_signal(erase_a),
        .vga_x(vx_a), .vga_y(vy_a), .vga_colour(vc_a), .vga_plot(plot_a),
        .frame_count(fc_a), .overrun(ov_a), .timeout_err(to_a)
    );

    frame_sequencer #(.NUM_SPRITES(N), .FRAME_TICKS(FT_B), .ERASE_HOLD(EH), .DRAW_TIMEOUT(DT)) dut_ovr (
        .clk(clk), .reset(reset), .sprite_finish(fin_b),
        .sprite_x(sx), .sprite_y(sy), .sprite_colour(sc),
        .draw_signal(draw_b), .erase_signal(erase_b),
        .vga_x(vx_b), .vga_y(vy_b), .vga_colour(vc_b), .vga_plot(plot_b),
        .frame_count(fc_b), .overrun(ov_b), .timeout_err(to_b)
    );

    int checks = 0;
    int errors = 0;
    int e      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, e, got, exp);
        end
    endtask

    // Frame-level model: each frame is a list of pulse start edges and lengths.
    int         g = 0;
    int         m_done, m_S, m_W, nxt_T, to_edge, ov_edge;
    bit         m_first;
    int         m_E [N];
    int         m_D [N];
    int         m_L [N];
    int         delay [N];
    int         hi_a [N];
    logic [8:0] xs [N];
    logic [7:0] ys [N];
    logic [2:0] cs [N];

    task automatic plan_frame(input bit first);
        int t, s, base;
        if (first) begin
            t = FT;
            s = FT + 1;
        end else begin
            t = nxt_T;
            s = ((t > m_W) ? t : m_W) + 1;
        end
        for (int i = 0; i < N; i++) begin
            if (g <= 1)      delay[i] = 43;
            else if (g == 2) delay[i] = (i == 1) ? 100000 : 43;
            else             delay[i] = $urandom_range(30, 70);
            xs[i] = 9'($urandom_range(0, 511));
            ys[i] = 8'($urandom_range(0, 255));
            cs[i] = 3'($urandom_range(0, 7));
        end
        if (g == 1) begin
            xs[2] = 9'd100;
            ys[2] = 8'd50;
            cs[2] = 3'd5;
        end
        for (int i = 0; i < N; i++) begin
            sx[9*i +: 9] = xs[i];
            sy[8*i +: 8] = ys[i];
            sc[3*i +: 3] = cs[i];
        end
        m_S  = s;
        base = s;
        for (int i = 0; i < N; i++) begin
            m_E[i] = first ? -NEVER : s + i * (EH + 1);
        end
        if (!first) base = s + N * (EH + 1);
        for (int i = 0; i < N; i++) begin
            m_L[i] = (delay[i] + 1 < DT) ? delay[i] + 1 : DT;
            m_D[i] = base;
            if (delay[i] + 1 > DT && base + DT < to_edge) to_edge = base + DT;
            base += m_L[i] + 1;
        end
        m_W   = base + 1;
        nxt_T = ((s + FT - 1) / FT) * FT;
        if (nxt_T + FT < ((nxt_T > m_W) ? nxt_T : m_W) + 1 && nxt_T + FT < ov_edge)
            ov_edge = nxt_T + FT;
        m_first = first;
        g++;
    endtask

    task automatic check_cycle();
        logic [N-1:0] ee, ed;
        logic         pl;
        int           act;
        while (e >= m_W) begin
            m_done++;
            $display("frame %0d complete at edge %0d (start %0d)", m_done, m_W, m_S);
            plan_frame(1'b0);
        end
        ee  = '0;
        ed  = '0;
        pl  = 1'b0;
        act = -1;
        for (int i = 0; i < N; i++) begin
            if (!m_first && e >= m_E[i] && e < m_E[i] + EH) begin
                ee[i] = 1'b1;
                act   = i;
                pl    = (e - m_E[i] >= PRE);
            end
            if (e >= m_D[i] && e < m_D[i] + m_L[i]) begin
                ed[i] = 1'b1;
                act   = i;
                pl    = (e - m_D[i] >= PRE);
            end
        end
        check("erase_signal", 32'(erase_a), 32'(ee));
        check("draw_signal", 32'(draw_a), 32'(ed));
        check("vga_plot", 32'(plot_a), 32'(pl));
        check("vga_x", 32'(vx_a), (act >= 0) ? 32'(xs[act]) : 32'd0);
        check("vga_y", 32'(vy_a), (act >= 0) ? 32'(ys[act]) : 32'd0);
        check("vga_colour", 32'(vc_a), (act >= 0) ? 32'(cs[act]) : 32'd0);
        check("frame_count", 32'(fc_a), 32'(m_done & 16'hffff));
        check("timeout_err", 32'(to_a), 32'(e >= to_edge));
        check("overrun", 32'(ov_a), 32'(e >= ov_edge));
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        @(negedge clk);
        check_cycle();
        for (int i = 0; i < N; i++) begin
            if (draw_a[i]) begin
                hi_a[i]++;
                fin_a[i] = (hi_a[i] > delay[i]);
            end else begin
                hi_a[i] = 0;
                fin_a[i] = 1'b0;
            end
        end
    endtask

    task automatic release_reset();
        reset   = 1'b1;
        e       = 0;
        m_done  = 0;
        to_edge = NEVER;
        ov_edge = NEVER;
        plan_frame(1'b1);
    endtask

    task automatic expect_all_zero(input string pfx);
        check({pfx, "_draw"}, 32'(draw_a), 32'd0);
        check({pfx, "_erase"}, 32'(erase_a), 32'd0);
        check({pfx, "_plot"}, 32'(plot_a), 32'd0);
        check({pfx, "_vga_x"}, 32'(vx_a), 32'd0);
        check({pfx, "_frame_count"}, 32'(fc_a), 32'd0);
        check({pfx, "_overrun"}, 32'(ov_a), 32'd0);
        check({pfx, "_timeout"}, 32'(to_a), 32'd0);
    endtask

    // Overrun instance: fixed-latency engines, one-hot and frame-count properties.
    int   hi_b [N];
    int   falls_b = 0;
    int   pend_b  = 0;
    logic prev_b  = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            falls_b = 0;
            pend_b  = 0;
            prev_b  = 1'b0;
            fin_b   = '0;
            for (int i = 0; i < N; i++) hi_b[i] = 0;
        end else begin
            check("b_one_hot", 32'($countones({draw_b, erase_b}) <= 1), 32'd1);
            if (prev_b && !draw_b[N-1]) begin
                falls_b++;
                pend_b = 2;
            end else if (pend_b > 0) begin
                pend_b--;
                if (pend_b == 0) check("b_frame_count", 32'(fc_b), 32'(falls_b));
            end
            prev_b = draw_b[N-1];
            for (int i = 0; i < N; i++) begin
                if (draw_b[i]) begin
                    hi_b[i]++;
                    fin_b[i] = (hi_b[i] > 10);
                end else begin
                    hi_b[i] = 0;
                    fin_b[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        int budget;
        reset = 1'b0;
        fin_a = '0;
        sx    = '0;
        sy    = '0;
        sc    = '0;
        for (int i = 0; i < N; i++) hi_a[i] = 0;
        repeat (3) @(negedge clk);
        expect_all_zero("reset");

        release_reset();
        budget = 0;
        while (m_done < 5 && budget < 4000) begin
            step();
            budget++;
        end
        check("frames_reached", 32'(m_done >= 5), 32'd1);

        // Land the reset in the middle of sprite 1's draw.
        budget = 0;
        while (e != m_D[1] + 10 && budget < 1000) begin
            step();
            budget++;
        end
        check("mid_draw_reached", 32'(draw_a), 32'd2);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        expect_all_zero("mid_reset");
        for (int i = 0; i < N; i++) begin
            hi_a[i] = 0;
            fin_a[i] = 1'b0;
        end
        @(negedge clk);

        release_reset();
        budget = 0;
        while (m_done < 2 && budget < 1500) begin
            step();
            budget++;
        end
        check("frames_after_reset", 32'(m_done >= 2), 32'd1);
        check("b_overrun", 32'(ov_b), 32'd1);
        check("b_frames_seen", 32'(falls_b > 0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Per-frame scheduler that sits directly upstream of the sprite engines (alien, player, bullet) and between them and the VGA adapter. On every frame tick it erases each sprite's previous image, then redraws each sprite in index order, driving each engine's draw_signal/erase_signal and waiting on its finish. It also multiplexes the active engine's pixel stream onto the single VGA adapter port, so only one engine plots at a time.

## Interface
Parameters:
- NUM_SPRITES, 3, number of sprite engines; index 0 is served first.
- FRAME_TICKS, 833333, clk cycles per frame (60 Hz at 50 MHz).
- ERASE_HOLD, 45, cycles erase_signal is held per sprite; exceeds the 40-pixel sprite sweep plus its 3 load/wait states.
- DRAW_TIMEOUT, 64, maximum cycles to wait for finish during draw.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low.
- sprite_finish  in  NUM_SPRITES  per-engine draw-complete level.
- sprite_x  in  9*NUM_SPRITES  packed engine x outputs, sprite i at bits [9i+8:9i].
- sprite_y  in  8*NUM_SPRITES  packed engine y outputs.
- sprite_colour  in  3*NUM_SPRITES  packed engine colour outputs.
- draw_signal  out  NUM_SPRITES  per-engine draw request, held level.
- erase_signal  out  NUM_SPRITES  per-engine erase request, held level.
- vga_x  out  9 / vga_y  out  8 / vga_colour  out  3  muxed pixel to the adapter.
- vga_plot  out  1  adapter write enable.
- frame_count  out  16  completed frames, wraps at 65535 -> 0.
- overrun  out  1  sticky: a tick arrived while one was already pending.
- timeout_err  out  1  sticky: some draw exceeded DRAW_TIMEOUT.

## Operation
- Tick generator: counter 0..FRAME_TICKS-1, one-cycle tick on wrap; tick sets a one-deep pending flag. Tick while pending already set -> overrun<=1, tick dropped.
- States: WAIT_FRAME, ERASE, DRAW, DONE. Index register idx (clog2 width).
- WAIT_FRAME: pending set -> clear pending, idx<=0, go ERASE, or go DRAW when first_frame is set (nothing on screen after reset).
- ERASE: erase_signal[idx]=1 for exactly ERASE_HOLD cycles; then idx+1, or idx<=0 and go DRAW after the last sprite.
- DRAW: draw_signal[idx]=1 until sprite_finish[idx]=1 or DRAW_TIMEOUT cycles elapse (timeout -> timeout_err<=1). Drop draw_signal, then advance to idx+1, or go DONE after the last sprite.
- DONE: frame_count+1, first_frame<=0, go WAIT_FRAME (one cycle).
- At most one bit of draw_signal|erase_signal is high at any time. A one-cycle all-zero gap separates consecutive requests, so every engine sees a clean rising edge.
- Mux: vga_x/y/colour = slice idx of the inputs. vga_plot=1 only in ERASE or DRAW, after the first 3 cycles of the request (engine load/wait states), and in DRAW only while sprite_finish[idx]=0.
- Reset (any state, including mid-draw): all outputs 0, state WAIT_FRAME, pending 0, first_frame 1, tick counter 0, sticky flags cleared.

## Timing
- Request outputs and vga_plot are registered; the pixel mux is combinational from idx.
- finish sampled at cycle k -> draw_signal low at k+1; next request high at k+2.
- First tick after reset occurs FRAME_TICKS cycles after reset release.
- Tick in same cycle as DONE: pending is set normally, sequence restarts from WAIT_FRAME the cycle after.
- Per-frame busy time with N sprites is at most N*(ERASE_HOLD+1) + N*(DRAW_TIMEOUT+1) + 1.

## Structure
- Package frame_seq_pkg: state enum, X_W=9, Y_W=8, C_W=3, the 3-cycle engine preamble constant.
- Sub-module frame_tick_gen (counter + tick pulse, parameter FRAME_TICKS); the rest lives in frame_sequencer.

## Test plan
Bench values: FRAME_TICKS=200, NUM_SPRITES=3, ERASE_HOLD=45, DRAW_TIMEOUT=64; behavioural engine models assert finish 43 cycles after draw rises.
- First frame after reset -> no erase_signal; draw_signal[0],[1],[2] in order, each high 44 cycles; frame_count=1.
- Second frame -> erase_signal[0..2] each high exactly 45 cycles with 1-cycle gaps, then three draws; frame_count=2.
- Engine 1 never finishes -> draw_signal[1] high 64 cycles, timeout_err=1, engine 2 still drawn.
- Drive x=100,y=50,colour=5 on slice 2 -> vga outputs match only during sprite 2's plot window; vga_plot=0 in WAIT_FRAME.
- FRAME_TICKS=50 (busy exceeds frame) -> overrun=1, frame_count advances once per completed sequence, no two request bits ever high together.
- Reset low mid-DRAW of sprite 1 -> next cycle all outputs 0; after release, next frame skips erase.
